// File: rtl/ssb_pkg.sv
// ssb_pkg: shared constants and types for the SSB (PSS/SSS) sequence generator.
//   - Sequence length and N_id limits, PSS/SSS cyclic-shift derivation constants
//   - m-sequence seeds and feedback taps for the three generator LFSRs
//   - Top-level state encoding
//   - BPSK bit convention (bit 1 maps to +1), shared with the receive-side SSS detector
package ssb_pkg;

    localparam int SEQ_LEN     = 127;
    localparam int N_ID_MAX    = 1007;
    localparam int N_ID_1_MAX  = 335;
    localparam int PSS_SHIFT   = 43;
    localparam int SSS_M0_STEP = 15;
    localparam int SSS_M0_N2   = 5;
    localparam int SSS_M1_MOD  = 112;

    // Seeds hold x(0) in bit 0 ... x(6) in bit 6.
    localparam logic [6:0] XP_INIT = 7'b1110110;
    localparam logic [6:0] X0_INIT = 7'b0000001;
    localparam logic [6:0] X1_INIT = 7'b0000001;

    // x(i+7) = x(i+TAP) ^ x(i)
    localparam int XP_TAP = 4;
    localparam int X0_TAP = 4;
    localparam int X1_TAP = 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CALC,
        PSS,
        SSS
    } ssb_state_e;

    // A BPSK bit equal to this value is transmitted as +1.
    localparam logic BPSK_POS_BIT = 1'b1;

    // Sequence index increment with wrap 126 -> 0.
    function automatic logic [6:0] idx_inc(input logic [6:0] idx);
        return (idx == 7'(SEQ_LEN - 1)) ? 7'd0 : idx + 7'd1;
    endfunction

endpackage

// File: rtl/ssb_lfsr_fill.sv
// ssb_lfsr_fill: runs a 7-stage Fibonacci LFSR for SEQ_LEN cycles after reset and
// captures one output bit per cycle into a SEQ_LEN-bit array (seq_o[i] = x(i)).
// Ports:
//   clk_i    - clock
//   reset_ni - asynchronous active-low reset; reloads the seed and restarts the fill
//   seq_o    - captured sequence, valid once done_o is high
//   done_o   - high from the cycle after the last bit is captured until reset
module ssb_lfsr_fill
    import ssb_pkg::*;
#(
    parameter int         TAP      = 4,
    parameter logic [6:0] INIT_VAL = 7'b0000001
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    output logic [SEQ_LEN-1:0] seq_o,
    output logic               done_o
);

    logic [6:0]         lfsr_q;
    logic [6:0]         cnt_q;
    logic               done_q;
    logic [SEQ_LEN-1:0] seq_q;

    // lfsr_q[k] holds x(i+k); the new top stage is x(i+7).
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lfsr_q <= INIT_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (!done_q) begin
            lfsr_q <= {lfsr_q[TAP] ^ lfsr_q[0], lfsr_q[6:1]};
            cnt_q  <= cnt_q + 7'd1;
            if (cnt_q == 7'(SEQ_LEN - 1)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Shift in from the top so that after SEQ_LEN shifts x(0) lands in bit 0.
    always_ff @(posedge clk_i) begin
        if (!done_q) begin
            seq_q <= {lfsr_q[0], seq_q[SEQ_LEN-1:1]};
        end
    end

    assign seq_o  = seq_q;
    assign done_o = done_q;

endmodule

// File: rtl/ssb_seq_gen.sv
// ssb_seq_gen: on request streams the 127-beat PSS followed by the 127-beat SSS
// for physical cell ID N_id as BPSK complex samples {imag = 0, real = +/-AMPLITUDE}.
// Ports:
//   clk_i, reset_ni          - clock, asynchronous active-low reset
//   s_axis_N_id_*            - request stream (tready high only in IDLE)
//   m_axis_out_tdata/tvalid/tready/tlast/tuser
//                            - sample stream; tlast on beat 126, tuser 0 = PSS, 1 = SSS
//   err_o                    - one-cycle pulse when a request with N_id > 1007 is dropped
//   busy_o                   - high whenever the generator is not IDLE
module ssb_seq_gen
    import ssb_pkg::*;
#(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 16384
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [9:0]        s_axis_N_id_tdata,
    input  logic              s_axis_N_id_tvalid,
    output logic              s_axis_N_id_tready,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic              m_axis_out_tuser,
    output logic              err_o,
    output logic              busy_o
);

    localparam int HALF = OUT_DW / 2;
    localparam int N1_W = $clog2(N_ID_1_MAX + 1);
    localparam logic signed [HALF-1:0] AMP_POS = HALF'(AMPLITUDE);
    localparam logic signed [HALF-1:0] AMP_NEG = -AMP_POS;

    function automatic logic [OUT_DW-1:0] bpsk_sample(input logic bit_v);
        logic signed [HALF-1:0] re;
        re = (bit_v == BPSK_POS_BIT) ? AMP_POS : AMP_NEG;
        return {{HALF{1'b0}}, re};
    endfunction

    logic [SEQ_LEN-1:0] xp_seq, x0_seq, x1_seq;
    logic               xp_done, x0_done, x1_done;
    logic               fill_done;

    ssb_lfsr_fill #(.TAP(XP_TAP), .INIT_VAL(XP_INIT)) u_xp (
        .clk_i(clk_i), .reset_ni(reset_ni), .seq_o(xp_seq), .done_o(xp_done));
    ssb_lfsr_fill #(.TAP(X0_TAP), .INIT_VAL(X0_INIT)) u_x0 (
        .clk_i(clk_i), .reset_ni(reset_ni), .seq_o(x0_seq), .done_o(x0_done));
    ssb_lfsr_fill #(.TAP(X1_TAP), .INIT_VAL(X1_INIT)) u_x1 (
        .clk_i(clk_i), .reset_ni(reset_ni), .seq_o(x1_seq), .done_o(x1_done));

    assign fill_done = xp_done & x0_done & x1_done;

    ssb_state_e        state_q;
    logic              tready_q, busy_q, err_q;
    logic [9:0]        n_id_p0;
    logic [6:0]        mp_p1, m0_p1, m1_p1;
    logic [6:0]        ip_q, i0_q, i1_q;
    logic [OUT_DW-1:0] out_data_p2;
    logic              out_vld_p2, out_last_p2, out_user_p2;
    logic              out_hs;

    // Derived cyclic shifts from the captured N_id (constant-divisor logic).
    logic [N1_W-1:0] n_id1_c;
    logic [1:0]      n_id2_c;
    logic [6:0]      mp_c, m0_c, m1_c;

    always_comb begin
        n_id1_c = N1_W'(n_id_p0 / 10'd3);
        n_id2_c = 2'(n_id_p0 % 10'd3);
        mp_c    = 7'(PSS_SHIFT * int'(n_id2_c));
        m0_c    = 7'(SSS_M0_STEP * int'(n_id1_c / N1_W'(SSS_M1_MOD)) + SSS_M0_N2 * int'(n_id2_c));
        m1_c    = 7'(n_id1_c % N1_W'(SSS_M1_MOD));
    end

    assign out_hs = out_vld_p2 & m_axis_out_tready;

    // Index pointers always address the beat that will be loaded next, so the
    // pointer equals its start value again exactly while beat 126 is presented.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= INIT;
            tready_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            n_id_p0     <= '0;
            mp_p1       <= '0;
            m0_p1       <= '0;
            m1_p1       <= '0;
            ip_q        <= '0;
            i0_q        <= '0;
            i1_q        <= '0;
            out_data_p2 <= '0;
            out_vld_p2  <= 1'b0;
            out_last_p2 <= 1'b0;
            out_user_p2 <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                INIT: begin
                    if (fill_done) begin
                        state_q  <= IDLE;
                        tready_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                // p0: request capture
                IDLE: begin
                    if (s_axis_N_id_tvalid && tready_q) begin
                        if (s_axis_N_id_tdata > 10'(N_ID_MAX)) begin
                            err_q <= 1'b1;
                        end else begin
                            n_id_p0  <= s_axis_N_id_tdata;
                            state_q  <= CALC;
                            tready_q <= 1'b0;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                // p1: derived shifts registered, PSS beat 0 loaded
                CALC: begin
                    mp_p1       <= mp_c;
                    m0_p1       <= m0_c;
                    m1_p1       <= m1_c;
                    ip_q        <= idx_inc(mp_c);
                    out_data_p2 <= bpsk_sample(~xp_seq[mp_c]);
                    out_vld_p2  <= 1'b1;
                    out_last_p2 <= 1'b0;
                    out_user_p2 <= 1'b0;
                    state_q     <= PSS;
                end
                // p2: output register advances one beat per handshake
                PSS: begin
                    if (out_hs) begin
                        if (ip_q == mp_p1) begin
                            out_data_p2 <= bpsk_sample(~(x0_seq[m0_p1] ^ x1_seq[m1_p1]));
                            out_last_p2 <= 1'b0;
                            out_user_p2 <= 1'b1;
                            i0_q        <= idx_inc(m0_p1);
                            i1_q        <= idx_inc(m1_p1);
                            state_q     <= SSS;
                        end else begin
                            out_data_p2 <= bpsk_sample(~xp_seq[ip_q]);
                            out_last_p2 <= (idx_inc(ip_q) == mp_p1);
                            ip_q        <= idx_inc(ip_q);
                        end
                    end
                end
                SSS: begin
                    if (out_hs) begin
                        if (i0_q == m0_p1) begin
                            out_data_p2 <= '0;
                            out_vld_p2  <= 1'b0;
                            out_last_p2 <= 1'b0;
                            out_user_p2 <= 1'b0;
                            state_q     <= IDLE;
                            tready_q    <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            out_data_p2 <= bpsk_sample(~(x0_seq[i0_q] ^ x1_seq[i1_q]));
                            out_last_p2 <= (idx_inc(i0_q) == m0_p1);
                            i0_q        <= idx_inc(i0_q);
                            i1_q        <= idx_inc(i1_q);
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign s_axis_N_id_tready = tready_q;
    assign m_axis_out_tdata   = out_data_p2;
    assign m_axis_out_tvalid  = out_vld_p2;
    assign m_axis_out_tlast   = out_last_p2;
    assign m_axis_out_tuser   = out_user_p2;
    assign err_o              = err_q;
    assign busy_o             = busy_q;

endmodule

// File: tb/tb_ssb_seq_gen.sv
// tb_ssb_seq_gen: scoreboard bench for ssb_seq_gen. Requests push the expected
// 254 beats into a queue; a monitor pops and compares on every output handshake.
module tb_ssb_seq_gen;

    localparam logic [31:0] POS = 32'h0000_4000;
    localparam logic [31:0] NEG = 32'h0000_C000;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [9:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        err_o;
    logic        busy_o;

    ssb_seq_gen #(.OUT_DW(32), .AMPLITUDE(16384)) dut (
        .clk_i              (clk_i),
        .reset_ni           (reset_ni),
        .s_axis_N_id_tdata  (s_tdata),
        .s_axis_N_id_tvalid (s_tvalid),
        .s_axis_N_id_tready (s_tready),
        .m_axis_out_tdata   (m_tdata),
        .m_axis_out_tvalid  (m_tvalid),
        .m_axis_out_tready  (m_tready),
        .m_axis_out_tlast   (m_tlast),
        .m_axis_out_tuser   (m_tuser),
        .err_o              (err_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    bit    rand_mode = 1'b0;
    beat_t exp_q[$];

    logic [126:0] mxp, mx0, mx1;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        if (rand_mode) m_tready = ($urandom_range(0, 99) < 30);
        else           m_tready = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: stall stability plus scoreboard comparison on every handshake.
    bit    stall_pend = 1'b0;
    beat_t stall_beat;
    always @(negedge clk_i) begin
        beat_t e;
        beat_t a;
        if (!reset_ni) begin
            stall_pend = 1'b0;
        end else begin
            a = '{data: m_tdata, last: m_tlast, user: m_tuser};
            if (stall_pend) begin
                tests++;
                if (!m_tvalid || a !== stall_beat) begin
                    fails++;
                    $display("FAIL stall_hold beat %0d: got vld=%b %h expected vld=1 %h",
                             beats_seen, m_tvalid, a, stall_beat);
                end
            end
            stall_pend = m_tvalid && !m_tready;
            stall_beat = a;
            if (m_tvalid && m_tready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got data=%h last=%b user=%b expected none",
                             m_tdata, m_tlast, m_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL beat %0d: got data=%h last=%b user=%b expected data=%h last=%b user=%b",
                                 beats_seen, a.data, a.last, a.user, e.data, e.last, e.user);
                    end
                end
                if (beats_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats_seen++;
            end
        end
    end

    task automatic build_model();
        mxp[6:0] = 7'b1110110;
        mx0[6:0] = 7'b0000001;
        mx1[6:0] = 7'b0000001;
        for (int j = 7; j < 127; j++) begin
            mxp[j] = mxp[j-3] ^ mxp[j-7];
            mx0[j] = mx0[j-3] ^ mx0[j-7];
            mx1[j] = mx1[j-6] ^ mx1[j-7];
        end
    endtask

    task automatic load_expected(input int id, input bit hand0);
        beat_t       arr[254];
        logic [31:0] hand_pss[7];
        int n2, n1, mp, m0, m1;
        hand_pss = '{POS, NEG, NEG, POS, NEG, NEG, NEG};
        n2 = id % 3;
        n1 = id / 3;
        mp = 43 * n2;
        m0 = 15 * (n1 / 112) + 5 * n2;
        m1 = n1 % 112;
        for (int n = 0; n < 127; n++) begin
            arr[n].data = mxp[(n + mp) % 127] ? NEG : POS;
            arr[n].last = (n == 126);
            arr[n].user = 1'b0;
            arr[127+n].data = (mx0[(n + m0) % 127] == mx1[(n + m1) % 127]) ? POS : NEG;
            arr[127+n].last = (n == 126);
            arr[127+n].user = 1'b1;
        end
        if (hand0) begin
            for (int n = 0; n < 7; n++) arr[n].data = hand_pss[n];
            for (int n = 0; n < 8; n++) arr[127+n].data = POS;
        end
        exp_q.delete();
        for (int n = 0; n < 254; n++) exp_q.push_back(arr[n]);
    endtask

    task automatic issue(input logic [9:0] id, output int hs, output bit ok);
        int n = 0;
        ok = 1'b0;
        hs = 0;
        @(negedge clk_i);
        s_tdata  = id;
        s_tvalid = 1'b1;
        while (!s_tready && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("req_accept_timeout", 32'(n < 1000), 32'd1);
        if (n < 1000) begin
            @(posedge clk_i);
            #1;
            hs = cyc;
            ok = 1'b1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic init_phase();
        int n = 0;
        int k = 0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        while (k < 400) begin
            @(negedge clk_i);
            k++;
            if (s_tready) break;
            if (busy_o) n++;
        end
        chk("init_busy_cycles", 32'(n), 32'd127);
        chk("init_tready", 32'(s_tready), 32'd1);
        chk("init_busy_low", 32'(busy_o), 32'd0);
        chk("xp_0_6", 32'(dut.xp_seq[6:0]), 32'h76);
    endtask

    task automatic run_case(input logic [9:0] id, input int emp, input int em0, input int em1,
                            input bit hand0, input bit slow);
        int hs;
        bit ok;
        int n = 0;
        load_expected(int'(id), hand0);
        beats_seen = 0;
        issue(id, hs, ok);
        if (ok) begin
            @(posedge clk_i);
            #1;
            chk("mp", 32'(dut.mp_p1), 32'(emp));
            chk("m0", 32'(dut.m0_p1), 32'(em0));
            chk("m1", 32'(dut.m1_p1), 32'(em1));
            while (exp_q.size() != 0 && n < 4000) begin
                @(negedge clk_i);
                #1;
                n++;
            end
            chk("drain_timeout", 32'(n < 4000), 32'd1);
            chk("first_latency", 32'(first_cyc), 32'(hs + 1));
            chk("beat_count", 32'(beats_seen), 32'd254);
            if (!slow) chk("contiguous", 32'(last_cyc - first_cyc), 32'd253);
            @(negedge clk_i);
            chk("idle_tready", 32'(s_tready), 32'd1);
            chk("idle_busy", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        int hs;
        bit ok;
        int n;
        reset_ni = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        build_model();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        init_phase();

        run_case(10'd0, 0, 0, 0, 1'b1, 1'b0);
        run_case(10'd1007, 86, 40, 111, 1'b0, 1'b0);

        // Out-of-range request: dropped with a single err pulse.
        beats_seen = 0;
        exp_q.delete();
        issue(10'd1008, hs, ok);
        chk("err_pulse", 32'(err_o), 32'd1);
        chk("err_tready", 32'(s_tready), 32'd1);
        @(posedge clk_i);
        #1;
        n = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (err_o) n++;
        end
        chk("err_once", 32'(n), 32'd0);
        chk("err_no_beats", 32'(beats_seen), 32'd0);
        chk("err_idle_tready", 32'(s_tready), 32'd1);

        rand_mode = 1'b1;
        run_case(10'd500, 86, 25, 54, 1'b0, 1'b1);
        rand_mode = 1'b0;

        // Reset while SSS beat 60 is on the bus.
        load_expected(0, 1'b1);
        beats_seen = 0;
        issue(10'd0, hs, ok);
        n = 0;
        while (beats_seen < 188 && n < 1000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("reach_sss60", 32'(n < 1000), 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_tdata", m_tdata, 32'd0);
        chk("midrst_tlast", 32'(m_tlast), 32'd0);
        chk("midrst_tuser", 32'(m_tuser), 32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        init_phase();
        run_case(10'd0, 0, 0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
